// File: rtl/window_mac.sv
// window_mac: pipelined signed dot product of a shift-register tap window with a loadable kernel.
// Optional build macro WINDOW_MAC_SATURATE_EN clamps the result to the signed DATA_WIDTH range.
module window_mac #(
    parameter int SIZE       = 5,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 35
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE*DATA_WIDTH-1:0]   window_in,
    input  logic                         window_valid,
    input  logic                         flush,
    input  logic                         kernel_load,
    input  logic [SIZE*DATA_WIDTH-1:0]   kernel_in,
    output logic [ACC_WIDTH-1:0]         result_out,
    output logic                         result_valid,
    output logic                         primed
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH  = $clog2(SIZE + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SIZE - 1);

    // Handshake: window_valid is a one-cycle strobe with no back-pressure; result_valid
    // follows three cycles later only for full windows, and flush wins over window_valid.

    logic signed [DATA_WIDTH-1:0] coef [SIZE];
    logic [CNT_WIDTH-1:0]         warm_count;
    logic signed [PROD_WIDTH-1:0] s1_prod [SIZE];
    logic                         s1_valid;
    logic                         s2_valid;
    logic                         s3_valid;
    logic signed [ACC_WIDTH-1:0]  sum_next;
    logic signed [ACC_WIDTH-1:0]  s2_sum;
    logic signed [ACC_WIDTH-1:0]  s3_value;
    logic [ACC_WIDTH-1:0]         result_q;
    logic                         accept;
    logic                         full;

    assign accept = window_valid & ~flush;
    assign full   = accept & (warm_count >= CNT_LAST);

    // The coefficient registers update on the same edge that S1 samples them,
    // so a colliding window still sees the old kernel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SIZE; k++) begin
                coef[k] <= '0;
            end
        end else if (kernel_load) begin
            for (int k = 0; k < SIZE; k++) begin
                coef[k] <= $signed(kernel_in[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warm_count <= '0;
        end else if (flush) begin
            warm_count <= '0;
        end else if (window_valid && (warm_count != CNT_FULL)) begin
            warm_count <= warm_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SIZE; k++) begin
                s1_prod[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < SIZE; k++) begin
                s1_prod[k] <= $signed(window_in[k*DATA_WIDTH +: DATA_WIDTH]) * coef[k];
            end
        end
    end

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < SIZE; k++) begin
            sum_next = sum_next + ACC_WIDTH'(s1_prod[k]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_sum <= '0;
        end else if (s1_valid) begin
            s2_sum <= sum_next;
        end
    end

`ifdef WINDOW_MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        s3_value = s2_sum;
        if (s2_sum > SAT_MAX) begin
            s3_value = SAT_MAX;
        end else if (s2_sum < SAT_MIN) begin
            s3_value = SAT_MIN;
        end
    end
`else
    always_comb begin
        s3_value = s2_sum;
    end
`endif

    // The output register only moves on a live full window, so bubbles and
    // flushed slots leave result_out holding its last value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if (s2_valid && !flush) begin
            result_q <= s3_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= full;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    assign result_out   = result_q;
    assign result_valid = s3_valid;
    assign primed       = (warm_count == CNT_FULL);

endmodule

// File: tb/tb_window_mac.sv
// Directed and random bench for window_mac; expected results are queued with their
// due cycle when a window is driven and checked cycle by cycle by a monitor.
module tb_window_mac;

    localparam int SIZE = 5;
    localparam int DW   = 16;
    localparam int AW   = 35;
    localparam int VW   = SIZE * DW;

    localparam logic [AW-1:0] EXP_SIGNED =
`ifdef WINDOW_MAC_SATURATE_EN
        -35'sd32768;
`else
        -35'sd98301;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] window_in = '0;
    logic          window_valid = 1'b0;
    logic          flush = 1'b0;
    logic          kernel_load = 1'b0;
    logic [VW-1:0] kernel_in = '0;
    logic [AW-1:0] result_out;
    logic          result_valid;
    logic          primed;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int mdl_count = 0;
    logic [VW-1:0] mdl_kernel = '0;
    logic [VW-1:0] sr = '0;
    logic [AW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    window_mac #(.SIZE(SIZE), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .window_in    (window_in),
        .window_valid (window_valid),
        .flush        (flush),
        .kernel_load  (kernel_load),
        .kernel_in    (kernel_in),
        .result_out   (result_out),
        .result_valid (result_valid),
        .primed       (primed)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [AW-1:0] ref_dot(input logic [VW-1:0] w, input logic [VW-1:0] k);
        longint acc = 0;
        for (int i = 0; i < SIZE; i++) begin
            acc += longint'($signed(w[i*DW +: DW])) * longint'($signed(k[i*DW +: DW]));
        end
`ifdef WINDOW_MAC_SATURATE_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return AW'(acc);
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < SIZE; i++) v[i*DW +: DW] = DW'($urandom());
        return v;
    endfunction

    function automatic logic [VW-1:0] shift_in(input logic [VW-1:0] s, input logic [DW-1:0] x);
        return {s[VW-DW-1:0], x};
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [VW-1:0] w, input logic f,
                        input logic kl, input logic [VW-1:0] k);
        @(posedge clock);
        #1;
        chk("primed", AW'(primed), AW'(mdl_count == SIZE));
        window_valid = v;
        window_in    = w;
        flush        = f;
        kernel_load  = kl;
        kernel_in    = k;
        if (f) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
                void'(exp_cyc_q.pop_back());
                void'(exp_q.pop_back());
            end
            mdl_count = 0;
        end else if (v) begin
            if (mdl_count >= SIZE - 1) begin
                exp_q.push_back(ref_dot(w, mdl_kernel));
                exp_cyc_q.push_back(cyc + 3);
            end
            if (mdl_count < SIZE) mdl_count++;
        end
        if (kl) mdl_kernel = k;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                chk("result_valid", AW'(result_valid), AW'(1));
                chk("result_out", result_out, e);
            end else begin
                chk("result_valid_idle", AW'(result_valid), AW'(0));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [VW-1:0] ones;
        logic [VW-1:0] twos;
        logic [VW-1:0] kr;
        ones = {SIZE{16'd1}};
        twos = {SIZE{16'd2}};

        #23;
        chk("reset_result_out", result_out, '0);
        chk("reset_result_valid", AW'(result_valid), '0);
        chk("reset_primed", AW'(primed), '0);
        #4 reset = 1'b0;

        // Warm-up: kernel of ones, samples 1..5 shifted in
        step(1'b0, '0, 1'b0, 1'b1, ones);
        sr = '0;
        for (int i = 1; i <= SIZE; i++) begin
            sr = shift_in(sr, DW'(i));
            step(1'b1, sr, 1'b0, 1'b0, '0);
        end
        idle(3);
        chk("warmup_valid", AW'(result_valid), AW'(1));
        chk("warmup_sum", result_out, AW'(15));
        chk("warmup_primed", AW'(primed), AW'(1));

        // Kernel load colliding with a window
        step(1'b1, ones, 1'b0, 1'b1, twos);
        step(1'b1, ones, 1'b0, 1'b0, '0);
        idle(2);
        chk("collide_old_kernel", result_out, AW'(5));
        idle(1);
        chk("collide_new_kernel", result_out, AW'(10));

        // Signed extremes
        kr = {16'hFFFB, 16'd4, 16'hFFFD, 16'd2, 16'hFFFF};
        step(1'b0, '0, 1'b0, 1'b1, kr);
        step(1'b1, {SIZE{16'h7FFF}}, 1'b0, 1'b0, '0);
        idle(3);
        chk("signed_sum", result_out, EXP_SIGNED);

        // Flush with bubbles
        kr = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        step(1'b0, '0, 1'b0, 1'b1, kr);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) idle(2);
            step(1'b1, rand_vec(), 1'b0, 1'b0, '0);
        end
        step(1'b1, rand_vec(), 1'b1, 1'b0, '0);
        step(1'b1, rand_vec(), 1'b0, 1'b0, '0);
        chk("flush_primed", AW'(primed), AW'(0));
        for (int i = 0; i < 7; i++) begin
            if (i == 5) idle(2);
            step(1'b1, rand_vec(), 1'b0, 1'b0, '0);
        end

        // Asynchronous reset while results are in flight
        @(posedge clock);
        #3;
        reset = 1'b1;
        window_valid = 1'b0;
        flush = 1'b0;
        kernel_load = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        mdl_count = 0;
        mdl_kernel = '0;
        #1;
        chk("async_reset_result_out", result_out, '0);
        chk("async_reset_result_valid", AW'(result_valid), '0);
        chk("async_reset_primed", AW'(primed), '0);
        #100 reset = 1'b0;

        // Random stream with three kernel loads
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
            step(1'b1, rand_vec(), 1'b0, (i == 0 || i == 70 || i == 140), rand_vec());
        end
        idle(6);
        chk("queue_drained", AW'(exp_q.size()), AW'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/window_mac.md
# window_mac

Pipelined multiply-accumulate stage directly downstream of `shift_register`. Takes the full parallel tap vector (`data_out`, SIZE × DATA_WIDTH) and computes the signed dot product of the tap window with a loadable kernel, one result per cycle. It suppresses results until the shift register has been filled with real samples. This forms the 1-D convolution core of the convolver datapath.

## Interface
- `SIZE`, 5, number of taps; must match the feeding `shift_register`
- `DATA_WIDTH`, 16, signed sample and coefficient width
- `ACC_WIDTH`, 35, signed result width; must be ≥ 2·DATA_WIDTH + clog2(SIZE)

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `window_in`  in  SIZE·DATA_WIDTH  tap vector
  - Tap k = `window_in[k·DATA_WIDTH +: DATA_WIDTH]`; tap 0 is the newest sample.
- `window_valid`  in  1  `window_in` holds a new window this cycle (one shift occurred)
- `flush`  in  1  synchronous restart of warm-up and pipeline
- `kernel_load`  in  1  latch `kernel_in` this cycle
- `kernel_in`  in  SIZE·DATA_WIDTH  coefficients; coefficient k multiplies tap k
- `result_out`  out  ACC_WIDTH  signed dot product
- `result_valid`  out  1  `result_out` is a valid full-window result
- `primed`  out  1  warm-up complete; SIZE windows accepted since reset or flush

## Operation
- **Reset (async):** kernel registers = 0; warm-up counter = 0; all pipeline valid bits = 0; product/sum registers = 0. Outputs after reset: `result_out`=0, `result_valid`=0, `primed`=0.
- **Warm-up counter:**
  - Range 0..SIZE. Increments on each accepted `window_valid` and saturates at SIZE.
  - `primed` = (count == SIZE).
  - A window is *full* when it is accepted while count ≥ SIZE−1, i.e. the SIZE-th and every later window. Non-full windows flow down the pipeline but their valid bit is 0.
- **Pipeline:** three register stages.
  - S1: SIZE signed products, tap k × coef k, each 2·DATA_WIDTH bits.
  - S2: signed sum of all products, sign-extended to ACC_WIDTH.
  - S3: output register, which drives `result_out` and `result_valid`.
  - Fully pipelined; accepts one window per cycle with no back-pressure.
- **Arithmetic:** all operands are two's complement. The sum is exact (no overflow is possible given the ACC_WIDTH rule) unless saturation is compiled in.
- **Kernel load:**
  - `kernel_in` is latched on the edge where `kernel_load`=1.
  - If `kernel_load` and `window_valid` are high in the same cycle, that window uses the old kernel. The new kernel applies from the next accepted window.
  - Loading does not affect warm-up or results already in flight.
- **Flush:**
  - Clears the warm-up counter and all stage valid bits on the next edge. Data registers are not cleared.
  - If `flush` and `window_valid` are high together, flush wins and the window is discarded.
  - Kernel is retained.
- **Idle cycles:** when `window_valid`=0, a bubble propagates. `result_valid` drops for one cycle per bubble. `result_out` holds its last value when S3 receives a bubble.

## Timing
- **Latency:** `window_valid` high in cycle N produces `result_valid` in cycle N+3, with the corresponding `result_out`.
- **Throughput:** continuous `window_valid` after warm-up gives `result_valid` high every cycle.
- **`primed` timing:** rises in the cycle after the SIZE-th accepted window. It falls in the cycle after `flush` and on `reset`.
- **Reset mid-operation:** all in-flight results are lost immediately (asynchronously). `result_valid`=0 until a new full window traverses the pipeline.
- **Flush mid-operation:** in-flight results are killed. After flush in cycle F, the earliest `result_valid` is F+1+(SIZE−1)+3, given back-to-back windows starting in F+1.

## Configuration
- `WINDOW_MAC_SATURATE_EN`
  - **Defined:** S3 clamps the S2 sum to the signed DATA_WIDTH range, [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], then sign-extends to ACC_WIDTH. Latency is unchanged.
  - **Undefined:** S3 passes the full-precision sum unmodified.

## Test plan
- **Reset values:** assert `reset` for 100 ns mid-stream → `result_out`=0, `result_valid`=0, `primed`=0 immediately, without waiting for a clock edge.
- **Warm-up:**
  - Setup: kernel all 1s; feed windows with taps 1,2,3,4,5 on consecutive cycles.
  - `result_valid` stays 0 for the first 4 windows.
  - 5th window → `result_valid`=1 three cycles later, `result_out`=15.
  - `primed`=1 from the cycle after the 5th window.
- **Signed math:**
  - Kernel {−1,2,−3,4,−5}, taps all 0x7FFF → result −98301 (full precision).
  - Same taps with `WINDOW_MAC_SATURATE_EN` defined → result −32768.
- **Kernel update collision:**
  - Kernel all 1s; assert `kernel_load` (new kernel all 2s) in the same cycle as window W (taps all 1) → W result = 5.
  - The next window with taps all 1 → result = 10.
- **Flush + bubbles:**
  - Stream 8 windows, then `flush` coincident with the 9th → the 9th is discarded; in-flight results are dropped.
  - `primed`=0 after the flush; the next 4 windows produce no `result_valid`.
  - Idle gaps of 2 cycles inside the stream give exactly 2-cycle gaps in `result_valid`.
- **Random stream:**
  - 200 random windows and 3 random kernel loads.
  - Compare each `result_out` against a bench reference dot product at N+3, with zero mismatches.
